// File: rtl/regfile_pkg.sv
// Shared defaults and read-port array typedefs for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_ADDR_BITS = 3;
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_RD_PORTS  = 2;
  localparam int unsigned DEF_ZERO_REG  = 0;
  localparam int unsigned MAX_RD_PORTS  = 4;

  typedef logic [DEF_RD_PORTS-1:0][DEF_ADDR_BITS-1:0] rd_addr_arr_t;
  typedef logic [DEF_RD_PORTS-1:0][DEF_DATA_BITS-1:0] rd_data_arr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register/busy mux, plus same-cycle write forwarding
// when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned ZERO_REG  = DEF_ZERO_REG
) (
  input  logic [ADDR_BITS-1:0]                          rd_addr,
  input  logic                                          rd_enable,
  input  logic [(1<<ADDR_BITS)-1:0][DATA_BITS-1:0]      regs,
  input  logic [(1<<ADDR_BITS)-1:0]                     busy_mask,
  input  logic                                          wr_active,
  input  logic [ADDR_BITS-1:0]                          wr_addr,
  input  logic [DATA_BITS-1:0]                          wr_data,
  output logic [DATA_BITS-1:0]                          rd_data,
  output logic                                          rd_busy
);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_enable) begin
      rd_data = regs[rd_addr];
      rd_busy = busy_mask[rd_addr];
`ifdef REGFILE_BYPASS_EN
      // Forward the in-flight write; a hardwired-zero r0 is never forwarded.
      if (wr_active && (wr_addr == rd_addr) && !((ZERO_REG != 0) && (rd_addr == '0))) begin
        rd_data = wr_data;
        rd_busy = 1'b0;
      end
`endif
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_active, wr_addr, wr_data};
`endif

endmodule

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard and RD_PORTS read ports.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned RD_PORTS  = DEF_RD_PORTS,
  parameter int unsigned ZERO_REG  = DEF_ZERO_REG
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [RD_PORTS-1:0][ADDR_BITS-1:0]    rd_addr,
  input  logic [RD_PORTS-1:0]                   rd_enable,
  output logic [RD_PORTS-1:0][DATA_BITS-1:0]    rd_data,
  output logic [RD_PORTS-1:0]                   rd_busy,
  input  logic [ADDR_BITS-1:0]                  wr_addr,
  input  logic                                  wr_enable,
  input  logic [DATA_BITS-1:0]                  wr_data,
  input  logic [ADDR_BITS-1:0]                  rsv_addr,
  input  logic                                  rsv_enable,
  output logic                                  rsv_ack,
  output logic [(1<<ADDR_BITS)-1:0]             busy_mask
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DEPTH-1:0][DATA_BITS-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]                busy_q, busy_d;
  logic                            wr_to_zero, rsv_to_zero, wr_active;

  // Next-state: a write clears its busy bit, an accepted reservation then sets its own.
  always_comb begin
    wr_to_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    rsv_to_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    wr_active   = wr_enable && !reset;
    rsv_ack     = 1'b0;
    regs_d      = regs_q;
    busy_d      = busy_q;
    if (!reset) begin
      rsv_ack = rsv_enable &&
                (!busy_q[rsv_addr] || (wr_enable && (wr_addr == rsv_addr)));
      if (wr_enable) begin
        if (!wr_to_zero) regs_d[wr_addr] = wr_data;
        busy_d[wr_addr] = 1'b0;
      end
      if (rsv_ack && !rsv_to_zero) busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    regfile_rd_port #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .ZERO_REG  (ZERO_REG)
    ) u_rd_port (
      .rd_addr   (rd_addr[p]),
      .rd_enable (rd_enable[p]),
      .regs      (regs_q),
      .busy_mask (busy_q),
      .wr_active (wr_active),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[p]),
      .rd_busy   (rd_busy[p])
    );
  end

endmodule
